// File: rtl/qr_pkg.sv
// Shared constants, state encoding and lane-slice helper for the QR column stages.
// Lanes are packed little-endian: element i sits at bits [32i+31:32i] of a column bus.
`ifndef QR_PKG_SV
`define QR_PKG_SV

`define QR_LANE(vec, i) vec[(i)*qr_pkg::W +: qr_pkg::W]

package qr_pkg;

    localparam int W     = 32;
    localparam int LANES = 4;
    localparam int FRAC  = 16;
    localparam int COL_W = W * LANES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC1  = 3'd1,
        MAC2  = 3'd2,
        MAC3  = 3'd3,
        READY = 3'd4
    } state_t;

endpackage

`endif

// File: rtl/h_column3_rebuild_vec4_scale_add.sv
// Four-lane combinational scale-and-accumulate: out[i] = acc_in[i] + ((s * v[i]) >>> FRAC).
// Products are full 64-bit signed; the kept window truncates toward -inf and sums wrap.
module vec4_scale_add
    import qr_pkg::*;
(
    input  logic [W-1:0]     s,
    input  logic [COL_W-1:0] v,
    input  logic [COL_W-1:0] acc_in,
    output logic [COL_W-1:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [2*W-1:0] s_ext;
            logic signed [2*W-1:0] v_ext;
            logic signed [2*W-1:0] prod;
            logic signed [2*W-1:0] prod_shr;
            logic        [W-1:0]   v_lane;

            assign v_lane   = `QR_LANE(v, gi);
            // Explicit sign extension keeps the multiply a true signed 64x64 operation.
            assign s_ext    = {{W{s[W-1]}}, s};
            assign v_ext    = {{W{v_lane[W-1]}}, v_lane};
            assign prod     = s_ext * v_ext;
            assign prod_shr = prod >>> FRAC;
            assign `QR_LANE(out, gi) = `QR_LANE(acc_in, gi) + W'(prod_shr);
        end
    endgenerate

endmodule

// File: rtl/h_column3_rebuild.sv
// Rebuilds H column 3 as R13*Q1 + R23*Q2 + R33*Q3 over three MAC cycles,
// reusing a single 4-lane scale-add datapath, behind the QR column-stage handshake.
module h_column3_rebuild
    import qr_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             accept_in,
    output logic             accept_out,
    output logic             ready_out,
    input  logic [COL_W-1:0] Q_col1,
    input  logic [COL_W-1:0] Q_col2,
    input  logic [COL_W-1:0] Q_col3,
    input  logic [W-1:0]     R13,
    input  logic [W-1:0]     R23,
    input  logic [W-1:0]     R33,
    output logic [COL_W-1:0] H_col_rec
);

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [COL_W-1:0]   q1_q, q1_d;
    logic [COL_W-1:0]   q2_q, q2_d;
    logic [COL_W-1:0]   q3_q, q3_d;
    logic [W-1:0]       r13_q, r13_d;
    logic [W-1:0]       r23_q, r23_d;
    logic [W-1:0]       r33_q, r33_d;
    logic [COL_W-1:0]   acc_q, acc_d;
    logic [COL_W-1:0]   h_q, h_d;

    logic [W-1:0]       mux_s;
    logic [COL_W-1:0]   mux_v;
    logic [COL_W-1:0]   mux_acc;
    logic [COL_W-1:0]   mac_out;

    // Operand select for the shared datapath; MAC1 starts from a zero accumulator.
    always_comb begin
        mux_s   = r13_q;
        mux_v   = q1_q;
        mux_acc = '0;
        case (state_q)
            MAC2: begin
                mux_s   = r23_q;
                mux_v   = q2_q;
                mux_acc = acc_q;
            end
            MAC3: begin
                mux_s   = r33_q;
                mux_v   = q3_q;
                mux_acc = acc_q;
            end
            default: ;
        endcase
    end

    vec4_scale_add u_scale_add (
        .s      (mux_s),
        .v      (mux_v),
        .acc_in (mux_acc),
        .out    (mac_out)
    );

    always_comb begin
        state_d = state_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        q3_d    = q3_q;
        r13_d   = r13_q;
        r23_d   = r23_q;
        r33_d   = r33_q;
        acc_d   = acc_q;
        h_d     = h_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    q1_d    = Q_col1;
                    q2_d    = Q_col2;
                    q3_d    = Q_col3;
                    r13_d   = R13;
                    r23_d   = R23;
                    r33_d   = R33;
                    state_d = MAC1;
                end
            end
            MAC1: begin
                acc_d   = mac_out;
                state_d = MAC2;
            end
            MAC2: begin
                acc_d   = mac_out;
                state_d = MAC3;
            end
            MAC3: begin
                h_d     = mac_out;
                state_d = READY;
            end
            READY: begin
                if (accept_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_out lags the READY state by one cycle, so it overlaps the accept edge.
    assign ready_d = (state_q == READY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            q1_q    <= '0;
            q2_q    <= '0;
            q3_q    <= '0;
            r13_q   <= '0;
            r23_q   <= '0;
            r33_q   <= '0;
            acc_q   <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            q3_q    <= q3_d;
            r13_q   <= r13_d;
            r23_q   <= r23_d;
            r33_q   <= r33_d;
            acc_q   <= acc_d;
            h_q     <= h_d;
        end
    end

    assign accept_out = (state_q == IDLE);
    assign ready_out  = ready_q;
    assign H_col_rec  = h_q;

endmodule

// File: tb/tb_h_column3_rebuild.sv
// Scoreboard bench for h_column3_rebuild: a reference model pushes expected columns at
// each enable, and results are popped and compared when ready_out rises.
module tb_h_column3_rebuild;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic         accept_in;
    logic         accept_out;
    logic         ready_out;
    logic [127:0] Q_col1, Q_col2, Q_col3;
    logic [31:0]  R13, R23, R33;
    logic [127:0] H_col_rec;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    h_column3_rebuild dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .accept_in  (accept_in),
        .accept_out (accept_out),
        .ready_out  (ready_out),
        .Q_col1     (Q_col1),
        .Q_col2     (Q_col2),
        .Q_col3     (Q_col3),
        .R13        (R13),
        .R23        (R23),
        .R33        (R33),
        .H_col_rec  (H_col_rec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] scale_lane(input logic [31:0] r, input logic [31:0] q);
        longint p;
        p = longint'($signed(r)) * longint'($signed(q));
        return 32'(p >>> 16);
    endfunction

    function automatic logic [127:0] model(input logic [127:0] q1, input logic [127:0] q2,
                                           input logic [127:0] q3, input logic [31:0] r13,
                                           input logic [31:0] r23, input logic [31:0] r33);
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[i*32 +: 32] = scale_lane(r13, q1[i*32 +: 32]) + scale_lane(r23, q2[i*32 +: 32])
                            + scale_lane(r33, q3[i*32 +: 32]);
        end
        return res;
    endfunction

    function automatic logic [127:0] vec4(input logic [31:0] l3, input logic [31:0] l2,
                                          input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [127:0] rand_col();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called just after a rising edge with the DUT in IDLE; returns just after the enable edge.
    task automatic start_op(input logic [127:0] q1, input logic [127:0] q2, input logic [127:0] q3,
                            input logic [31:0] r13, input logic [31:0] r23, input logic [31:0] r33);
        Q_col1 = q1; Q_col2 = q2; Q_col3 = q3;
        R13 = r13; R23 = r23; R33 = r33;
        enable = 1'b1;
        exp_q.push_back(model(q1, q2, q3, r13, r23, r33));
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_ready(output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (ready_out === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_accept();
        accept_in = 1'b1;
        @(posedge clk);
        #1;
        accept_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; accept_in = 1'b0;
        Q_col1 = '0; Q_col2 = '0; Q_col3 = '0; R13 = '0; R23 = '0; R33 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (accept_out !== 1'b1 || ready_out !== 1'b0 || H_col_rec !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_hold: accept_out=%b ready_out=%b H=%h required 1 0 0",
                     accept_out, ready_out, H_col_rec);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (accept_out !== 1'b1 || ready_out !== 1'b0 || H_col_rec !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_release: accept_out=%b ready_out=%b H=%h required 1 0 0",
                     accept_out, ready_out, H_col_rec);
        end
        $display("[TB] reset: accept_out=%b ready_out=%b H=%h", accept_out, ready_out, H_col_rec);
    endtask

    task automatic test_identity();
        int cyc; bit to; logic [127:0] exp;
        start_op(vec4(0, 0, 0, 32'h0001_0000), vec4(0, 0, 32'h0001_0000, 0),
                 vec4(0, 32'h0001_0000, 0, 0), 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
        wait_ready(cyc, to);
        exp = exp_q.pop_front();
        n_tests++;
        if (to || cyc != 4) begin
            n_fail++;
            $display("FAIL identity_latency: timed_out=%b cycles=%0d required 4", to, cyc);
        end
        n_tests++;
        if (H_col_rec !== vec4(0, 32'h0004_0000, 32'h0003_0000, 32'h0002_0000)) begin
            n_fail++;
            $display("FAIL identity_value: got %h required %h", H_col_rec,
                     vec4(0, 32'h0004_0000, 32'h0003_0000, 32'h0002_0000));
        end
        n_tests++;
        if (H_col_rec !== exp) begin
            n_fail++;
            $display("FAIL identity_model: got %h required %h", H_col_rec, exp);
        end
        $display("[TB] identity: H=%h latency=%0d", H_col_rec, cyc);
        do_accept();
        n_tests++;
        if (ready_out !== 1'b1 || accept_out !== 1'b1 || H_col_rec !== exp) begin
            n_fail++;
            $display("FAIL identity_extra_cycle: ready_out=%b accept_out=%b H=%h required 1 1 %h",
                     ready_out, accept_out, H_col_rec, exp);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_ready_drop: ready_out=%b required 0", ready_out);
        end
    endtask

    task automatic test_signed_frac();
        int cyc; bit to; logic [127:0] exp; logic [127:0] half;
        half = {4{32'h0000_8000}};
        start_op(half, half, half, 32'hFFFF_0000, 32'h0000_4000, 32'h0);
        wait_ready(cyc, to);
        exp = exp_q.pop_front();
        n_tests++;
        if (to || H_col_rec !== {4{32'hFFFF_A000}}) begin
            n_fail++;
            $display("FAIL signed_frac: timed_out=%b got %h required %h", to, H_col_rec,
                     {4{32'hFFFF_A000}});
        end
        n_tests++;
        if (H_col_rec !== exp) begin
            n_fail++;
            $display("FAIL signed_frac_model: got %h required %h", H_col_rec, exp);
        end
        $display("[TB] signed_frac: H=%h", H_col_rec);
        do_accept();
    endtask

    task automatic test_hold_stability();
        int cyc; bit to; logic [127:0] exp;
        start_op(rand_col(), rand_col(), rand_col(), $urandom(), $urandom(), $urandom());
        Q_col1 = rand_col(); Q_col2 = rand_col(); Q_col3 = rand_col();
        R13 = $urandom(); R23 = $urandom(); R33 = $urandom();
        wait_ready(cyc, to);
        exp = exp_q.pop_front();
        n_tests++;
        if (to || H_col_rec !== exp) begin
            n_fail++;
            $display("FAIL hold_capture: timed_out=%b got %h required %h", to, H_col_rec, exp);
        end
        $display("[TB] hold_capture: H=%h", H_col_rec);
        for (int i = 0; i < 10; i++) begin
            enable = (i % 2 == 0);
            Q_col1 = rand_col(); R13 = $urandom();
            @(posedge clk);
            #1;
            n_tests++;
            if (ready_out !== 1'b1 || H_col_rec !== exp || accept_out !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: ready_out=%b accept_out=%b H=%h required 1 0 %h",
                         i, ready_out, accept_out, H_col_rec, exp);
            end
        end
        enable = 1'b0;
        do_accept();
        repeat (6) @(posedge clk);
        #1;
        n_tests++;
        if (ready_out !== 1'b0 || accept_out !== 1'b1 || H_col_rec !== exp) begin
            n_fail++;
            $display("FAIL hold_no_spurious: ready_out=%b accept_out=%b H=%h required 0 1 %h",
                     ready_out, accept_out, H_col_rec, exp);
        end
        $display("[TB] hold_done: ready_out=%b H=%h", ready_out, H_col_rec);
    endtask

    task automatic test_wrap();
        int cyc; bit to; logic [127:0] exp;
        start_op({4{32'h7FFF_0000}}, rand_col(), rand_col(), 32'h0002_0000, 32'h0, 32'h0);
        wait_ready(cyc, to);
        exp = exp_q.pop_front();
        n_tests++;
        if (to || H_col_rec !== {4{32'hFFFE_0000}}) begin
            n_fail++;
            $display("FAIL wrap: timed_out=%b got %h required %h", to, H_col_rec,
                     {4{32'hFFFE_0000}});
        end
        n_tests++;
        if (H_col_rec !== exp) begin
            n_fail++;
            $display("FAIL wrap_model: got %h required %h", H_col_rec, exp);
        end
        $display("[TB] wrap: H=%h", H_col_rec);
        do_accept();
    endtask

    task automatic test_reset_mid_op();
        int cyc; bit to; logic [127:0] exp;
        start_op(rand_col(), rand_col(), rand_col(), $urandom(), $urandom(), $urandom());
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        n_tests++;
        if (accept_out !== 1'b1 || ready_out !== 1'b0 || H_col_rec !== 128'h0) begin
            n_fail++;
            $display("FAIL midop_reset: accept_out=%b ready_out=%b H=%h required 1 0 0",
                     accept_out, ready_out, H_col_rec);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (ready_out !== 1'b0 || accept_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_no_resume: ready_out=%b accept_out=%b required 0 1",
                     ready_out, accept_out);
        end
        start_op(rand_col(), rand_col(), rand_col(), $urandom(), $urandom(), $urandom());
        wait_ready(cyc, to);
        exp = exp_q.pop_front();
        n_tests++;
        if (to || cyc != 4 || H_col_rec !== exp) begin
            n_fail++;
            $display("FAIL midop_fresh: timed_out=%b cycles=%0d got %h required %h",
                     to, cyc, H_col_rec, exp);
        end
        $display("[TB] reset_mid_op: fresh H=%h", H_col_rec);
        do_accept();
    endtask

    task automatic test_back_to_back();
        int cyc; bit to; logic [127:0] exp;
        for (int t = 0; t < 4; t++) begin
            start_op(rand_col(), rand_col(), rand_col(), $urandom(), $urandom(), $urandom());
            wait_ready(cyc, to);
            exp = exp_q.pop_front();
            n_tests++;
            if (to || cyc != 4 || H_col_rec !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d: timed_out=%b cycles=%0d got %h required %h",
                         t, to, cyc, H_col_rec, exp);
            end
            $display("[TB] b2b_%0d: H=%h", t, H_col_rec);
            do_accept();
        end
        accept_in = 1'b1;
        start_op(rand_col(), rand_col(), rand_col(), $urandom(), $urandom(), $urandom());
        wait_ready(cyc, to);
        exp = exp_q.pop_front();
        n_tests++;
        if (to || cyc != 4 || H_col_rec !== exp || accept_out !== 1'b1) begin
            n_fail++;
            $display("FAIL held_accept: timed_out=%b cycles=%0d accept_out=%b got %h required %h",
                     to, cyc, accept_out, H_col_rec, exp);
        end
        $display("[TB] held_accept: H=%h accept_out=%b", H_col_rec, accept_out);
        accept_in = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (ready_out !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_accept_drop: ready_out=%b pending=%0d required 0 0",
                     ready_out, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed_frac();
        test_hold_stability();
        test_wrap();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
